aes_block_loader: RTL

AES_BLOCK_LOADER -- requirements
Module: aes_block_loader

---
 rtl/aes_pkg.sv | 16 +
 rtl/aes_valid_delay.sv | 31 +++
 rtl/aes_block_loader.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared FSM state type and constants for the AES block loader
// Purpose : state enum, words-per-block count and default cipher latency used by
//           aes_block_loader and its bench.
// Ports   : none (package).
package aes_pkg;

   typedef enum logic [1:0] {
      NOKEY   = 2'd0,
      KEYGRP  = 2'd1,
      DATAGRP = 2'd2
   } loader_state_t;

   localparam int WORDS_PER_BLOCK = 4;
   localparam int DEF_CIPHER_LAT  = 11;

endpackage

// File: rtl/aes_valid_delay.sv
// rtl/aes_valid_delay.sv - DEPTH-cycle shift register delaying a strobe
// Purpose : delays a one-bit strobe by exactly DEPTH clock cycles.
// Ports   : clk    - clock, rising edge
//           nrst   - synchronous active-low reset, clears every stage
//           i_in   - strobe in
//           o_out  - strobe out, DEPTH cycles after i_in
module aes_valid_delay #(
   parameter int DEPTH = 11
) (
   input  logic clk,
   input  logic nrst,
   input  logic i_in,
   output logic o_out
);

   logic [DEPTH-1:0] r_sr;

   always_ff @(posedge clk) begin
      if (!nrst) begin
         r_sr <= '0;
      end else begin
         r_sr[0] <= i_in;
         for (int i = 1; i < DEPTH; i++) begin
            r_sr[i] <= r_sr[i-1];
         end
      end
   end

   assign o_out = r_sr[DEPTH-1];

endmodule

// File: rtl/aes_block_loader.sv
// rtl/aes_block_loader.sv - packs input words into AES key/plaintext blocks
// Purpose : groups 4 accepted DWORD words into a LENGTH-bit block; the first
//           word's s_key selects key or plaintext. Key blocks update Key,
//           plaintext blocks update Plain_Text with a one-cycle pt_valid, and
//           ct_valid follows pt_valid after CIPHER_LAT cycles.
// Ports   : clk, nrst (sync, active-low)
//           s_data/s_key/s_valid/s_ready - word input handshake
//           Plain_Text, Key, pt_valid    - block presented to the cipher
//           ct_valid                     - cipher output valid strobe
//           key_loaded                   - a key has been committed since reset
//           blk_cnt                      - saturating block count, only when
//                                          AES_LOADER_BLKCNT_EN is defined
module aes_block_loader
   import aes_pkg::*;
#(
   parameter int DWORD      = 32,
   parameter int LENGTH     = 128,
   parameter int CIPHER_LAT = DEF_CIPHER_LAT
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic [DWORD-1:0]  s_data,
   input  logic              s_key,
   input  logic              s_valid,
   output logic              s_ready,
   output logic [LENGTH-1:0] Plain_Text,
   output logic [LENGTH-1:0] Key,
   output logic              pt_valid,
   output logic              ct_valid,
`ifdef AES_LOADER_BLKCNT_EN
   output logic [15:0]       blk_cnt,
`endif
   output logic              key_loaded
);

   localparam int         SHW       = LENGTH - DWORD;
   localparam logic [1:0] LAST_WORD = 2'(WORDS_PER_BLOCK - 1);

   loader_state_t     r_state, w_state_nxt;
   logic [1:0]        r_wcnt, w_wcnt_nxt;
   logic [SHW-1:0]    r_shadow;
   logic [LENGTH-1:0] r_pt, r_key;
   logic              r_pt_valid, r_key_loaded;
   logic              w_accept, w_key_commit, w_pt_commit;
   logic              w_ct_valid;

   always_ff @(posedge clk) begin
      if (!nrst) begin
         r_state <= NOKEY;
         r_wcnt  <= 2'd0;
      end else begin
         r_state <= w_state_nxt;
         r_wcnt  <= w_wcnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_wcnt_nxt   = r_wcnt;
      s_ready      = 1'b0;
      w_accept     = 1'b0;
      w_key_commit = 1'b0;
      w_pt_commit  = 1'b0;
      case (r_state)
         NOKEY: begin
            // only a key word may start traffic; plaintext stalls here
            s_ready  = s_valid & s_key;
            w_accept = s_valid & s_key;
            if (w_accept) begin
               w_state_nxt = KEYGRP;
               w_wcnt_nxt  = 2'd1;
            end
         end
         KEYGRP: begin
            s_ready  = 1'b1;
            w_accept = s_valid;
            if (w_accept) begin
               if (r_wcnt == LAST_WORD) begin
                  w_key_commit = 1'b1;
                  w_state_nxt  = DATAGRP;
                  w_wcnt_nxt   = 2'd0;
               end else begin
                  w_wcnt_nxt = r_wcnt + 2'd1;
               end
            end
         end
         DATAGRP: begin
            s_ready  = 1'b1;
            w_accept = s_valid;
            if (w_accept) begin
               if (r_wcnt == 2'd0 && s_key) begin
                  w_state_nxt = KEYGRP;
                  w_wcnt_nxt  = 2'd1;
               end else if (r_wcnt == LAST_WORD) begin
                  w_pt_commit = 1'b1;
                  w_wcnt_nxt  = 2'd0;
               end else begin
                  w_wcnt_nxt = r_wcnt + 2'd1;
               end
            end
         end
         default: begin
            w_state_nxt = NOKEY;
            w_wcnt_nxt  = 2'd0;
         end
      endcase
   end

   // Words shift in from the bottom, so after three words the shadow holds
   // {w1,w2,w3} and the fourth word completes the block in the low bits.
   // Stale upper bits from an earlier group are shifted out by then.
   always_ff @(posedge clk) begin
      if (!nrst) begin
         r_shadow     <= '0;
         r_pt         <= '0;
         r_key        <= '0;
         r_pt_valid   <= 1'b0;
         r_key_loaded <= 1'b0;
      end else begin
         r_pt_valid <= w_pt_commit;
         if (w_accept) begin
            r_shadow <= {r_shadow[SHW-DWORD-1:0], s_data};
         end
         if (w_key_commit) begin
            r_key        <= {r_shadow, s_data};
            r_key_loaded <= 1'b1;
         end
         if (w_pt_commit) begin
            r_pt <= {r_shadow, s_data};
         end
      end
   end

   aes_valid_delay #(
      .DEPTH (CIPHER_LAT)
   ) u_ct_delay (
      .clk   (clk),
      .nrst  (nrst),
      .i_in  (r_pt_valid),
      .o_out (w_ct_valid)
   );

`ifdef AES_LOADER_BLKCNT_EN
   logic [15:0] r_blk_cnt;

   always_ff @(posedge clk) begin
      if (!nrst) begin
         r_blk_cnt <= 16'd0;
      end else if (r_pt_valid && r_blk_cnt != 16'hFFFF) begin
         r_blk_cnt <= r_blk_cnt + 16'd1;
      end
   end

   assign blk_cnt = r_blk_cnt;
`endif

   assign Plain_Text = r_pt;
   assign Key        = r_key;
   assign pt_valid   = r_pt_valid;
   assign ct_valid   = w_ct_valid;
   assign key_loaded = r_key_loaded;

endmodule
